// File: rtl/jmb_scanline_feeder.sv
// Scanline sequencer for jmb_scanline_filter: accepts W pixels per line and
// emits W+2 tap-window writes (edges replicated) so the filter yields W outputs.
module jmb_scanline_feeder #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 12,
  parameter int LINE_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      line_width,
  input  logic [DATA_W-1:0]     s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  filt_enable,
  output logic [DATA_W-1:0]     filt_pixel,
  output logic                  filt_wr,
  output logic                  filt_filter,
  output logic                  busy,
  output logic                  line_done,
  output logic [LINE_CNT_W-1:0] line_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_DUP   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_EDGE  = 3'd4;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      width_q, width_d;
  logic [CNT_W-1:0]      col_q, col_d;
  logic [DATA_W-1:0]     last_q, last_d;
  logic [DATA_W-1:0]     pix_q, pix_d;
  logic                  wr_q, wr_d;
  logic                  filt_q, filt_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic [LINE_CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    col_d   = col_q;
    last_d  = last_q;
    pix_d   = pix_q;
    wr_d    = 1'b0;
    filt_d  = 1'b0;
    done_d  = 1'b0;
    count_d = count_q;
    // Enable stays up through the cycle that shows the EDGE beat.
    en_d    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d    = 1'b1;
          width_d = (line_width == '0) ? ONE : line_width;
          col_d   = '0;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (s_valid) begin
          last_d  = s_pixel;
          pix_d   = s_pixel;
          wr_d    = 1'b1;
          state_d = S_DUP;
        end
      end
      S_DUP: begin
        pix_d   = last_q;
        wr_d    = 1'b1;
        state_d = (width_q == ONE) ? S_EDGE : S_RUN;
      end
      S_RUN: begin
        if (s_valid) begin
          pix_d  = s_pixel;
          last_d = s_pixel;
          wr_d   = 1'b1;
          filt_d = 1'b1;
          col_d  = col_q + ONE;
          // RUN consumes pixels 1..W-1; p0 was taken in FIRST.
          if ((col_q + ONE) == (width_q - ONE)) state_d = S_EDGE;
        end
      end
      S_EDGE: begin
        pix_d   = last_q;
        wr_d    = 1'b1;
        filt_d  = 1'b1;
        done_d  = 1'b1;
        count_d = count_q + LINE_CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      width_q <= '0;
      col_q   <= '0;
      last_q  <= '0;
      pix_q   <= '0;
      wr_q    <= 1'b0;
      filt_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      col_q   <= col_d;
      last_q  <= last_d;
      pix_q   <= pix_d;
      wr_q    <= wr_d;
      filt_q  <= filt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign s_ready     = (state_q == S_FIRST) || (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign filt_enable = en_q;
  assign filt_pixel  = pix_q;
  assign filt_wr     = wr_q;
  assign filt_filter = filt_q;
  assign line_done   = done_q;
  assign line_count  = count_q;

endmodule

// File: tb/tb_jmb_scanline_feeder.sv
// Self-checking bench for jmb_scanline_feeder: directed scenarios plus random
// lines checked against a per-line expected beat list built from the line's pixels.
module tb_jmb_scanline_feeder;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 12;
  localparam int LINE_CNT_W = 4;   // narrow so the wrap is reached quickly

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic [CNT_W-1:0]      line_width;
  logic [DATA_W-1:0]     s_pixel;
  logic                  s_valid;
  logic                  s_ready;
  logic                  filt_enable;
  logic [DATA_W-1:0]     filt_pixel;
  logic                  filt_wr;
  logic                  filt_filter;
  logic                  busy;
  logic                  line_done;
  logic [LINE_CNT_W-1:0] line_count;

  jmb_scanline_feeder #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LINE_CNT_W(LINE_CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .line_width(line_width),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .filt_enable(filt_enable), .filt_pixel(filt_pixel), .filt_wr(filt_wr),
    .filt_filter(filt_filter), .busy(busy), .line_done(line_done),
    .line_count(line_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       wr;
    logic       filt;
    logic [7:0] pix;
    logic       ready;
    logic       done;
    logic       busy;
    logic       en;
  } trace_t;

  int         checks = 0;
  int         errors = 0;
  int         exp_lines = 0;
  trace_t     tr_q[$];
  logic [7:0] line_px[$];

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(8'($urandom));
  endtask

  task automatic idle_check(input string tag);
    step();
    chk({tag, "_enable_low"}, filt_enable, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_no_wr"}, filt_wr, 0);
  endtask

  // Drives one line starting in the current (IDLE) cycle, records a per-cycle
  // trace up to and including the line_done cycle, and checks it.
  task automatic run_line(input int wf, input logic [63:0] stall_mask, input int start_at);
    int         w, idx, cyc, nb, ndone, bad_hold, bad_busy, bad_en, bad_filt;
    bit         seen;
    bit         stall;
    trace_t     t;
    logic [7:0] exp_pix[$];
    logic       exp_filt[$];
    w = (wf == 0) ? 1 : wf;
    exp_pix.push_back(line_px[0]);  exp_filt.push_back(1'b0);
    exp_pix.push_back(line_px[0]);  exp_filt.push_back(1'b0);
    for (int i = 1; i < w; i++) begin
      exp_pix.push_back(line_px[i]); exp_filt.push_back(1'b1);
    end
    exp_pix.push_back(line_px[w-1]); exp_filt.push_back(1'b1);

    tr_q.delete();
    start = 1'b1;
    line_width = CNT_W'(wf);
    step();
    start = 1'b0;
    idx = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 400) begin
      tr_q.push_back('{filt_wr, filt_filter, filt_pixel, s_ready, line_done, busy, filt_enable});
      if (line_done) begin
        seen = 1;
      end else begin
        start      = (cyc == start_at);
        line_width = CNT_W'($urandom);
        stall      = (cyc < 64) ? stall_mask[cyc] : 1'b0;
        s_valid    = (idx < w) && !stall;
        s_pixel    = s_valid ? line_px[idx] : 8'($urandom);
        if (s_valid && s_ready) idx++;
        step();
        cyc++;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("line_done_seen", 32'(seen), 1);

    nb = 0; ndone = 0; bad_hold = 0; bad_busy = 0; bad_en = 0; bad_filt = 0;
    foreach (tr_q[i]) begin
      t = tr_q[i];
      if (t.wr) begin
        if (nb < exp_pix.size()) begin
          chk($sformatf("beat%0d_pix", nb), t.pix, exp_pix[nb]);
          chk($sformatf("beat%0d_filt", nb), t.filt, exp_filt[nb]);
        end
        nb++;
      end else begin
        if (t.filt) bad_filt++;
        if (i > 0 && t.pix !== tr_q[i-1].pix) bad_hold++;
      end
      if (t.done) ndone++;
      if (t.en !== 1'b1) bad_en++;
      if (i < tr_q.size() - 1 && t.busy !== 1'b1) bad_busy++;
    end
    chk("beat_count", nb, exp_pix.size());
    chk("done_pulses", ndone, 1);
    chk("last_beat_done", tr_q[tr_q.size()-1].done, 1);
    chk("last_cycle_not_busy", tr_q[tr_q.size()-1].busy, 0);
    chk("busy_profile", bad_busy, 0);
    chk("enable_profile", bad_en, 0);
    chk("pixel_hold", bad_hold, 0);
    chk("filt_without_wr", bad_filt, 0);
    exp_lines++;
    chk("line_count", 32'(line_count), exp_lines % (1 << LINE_CNT_W));
    $display("line W=%0d beats=%0d cycles=%0d line_count=%0d", w, nb, tr_q.size(), line_count);
  endtask

  initial begin : stim
    int     s1_wr[7];
    int     s1_filt[7];
    int     s1_pix[7];
    int     s1_ready[7];
    int     nfilt, cyc, bad;
    logic [63:0] mask;
    logic [LINE_CNT_W-1:0] lc;

    s1_wr    = '{0, 1, 1, 1, 1, 1, 1};
    s1_filt  = '{0, 0, 0, 1, 1, 1, 1};
    s1_pix   = '{0, 10, 10, 20, 30, 40, 40};
    s1_ready = '{1, 0, 1, 1, 1, 0, 0};

    reset = 1'b1; start = 1'b0; line_width = '0; s_pixel = '0; s_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_enable", filt_enable, 0);
    chk("rst_pixel", filt_pixel, 0);
    chk("rst_wr", filt_wr, 0);
    chk("rst_filter", filt_filter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", line_done, 0);
    chk("rst_count", line_count, 0);
    chk("rst_ready", s_ready, 0);

    // W=4, continuous valid: exact cycle profile
    line_px = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_line(4, 64'h0, -1);
    chk("s1_trace_len", tr_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < tr_q.size()) begin
        chk($sformatf("s1_c%0d_wr", i), tr_q[i].wr, s1_wr[i]);
        chk($sformatf("s1_c%0d_filt", i), tr_q[i].filt, s1_filt[i]);
        chk($sformatf("s1_c%0d_ready", i), tr_q[i].ready, s1_ready[i]);
        if (i > 0) chk($sformatf("s1_c%0d_pix", i), tr_q[i].pix, s1_pix[i]);
      end
    end
    idle_check("s1_after");

    // W=4 with two stalled cycles before pixel 30
    line_px = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_line(4, 64'h18, -1);
    chk("s2_trace_len", tr_q.size(), 9);
    for (int i = 4; i < 6; i++) begin
      if (i < tr_q.size()) begin
        chk($sformatf("s2_stall%0d_wr", i), tr_q[i].wr, 0);
        chk($sformatf("s2_stall%0d_pix", i), tr_q[i].pix, 20);
        chk($sformatf("s2_stall%0d_busy", i), tr_q[i].busy, 1);
      end
    end
    idle_check("s2_after");

    // W=1 then W=0 (treated as 1)
    line_px = '{8'd7};
    run_line(1, 64'h0, -1);
    chk("w1_trace_len", tr_q.size(), 4);
    idle_check("w1_after");
    line_px = '{8'd7};
    run_line(0, 64'h0, -1);
    chk("w0_trace_len", tr_q.size(), 4);
    idle_check("w0_after");

    // W=5 with a start pulse mid-line, then a back-to-back line
    fill_rand(5);
    run_line(5, 64'h0, 3);
    fill_rand(3);
    run_line(3, 64'h0, -1);
    chk("b2b_trace_len", tr_q.size(), 6);
    idle_check("b2b_after");

    // Reset after two RUN beats of a W=8 line
    line_width = CNT_W'(8); start = 1'b1; step(); start = 1'b0;
    nfilt = 0; cyc = 0;
    while (nfilt < 2 && cyc < 100) begin
      if (filt_wr && filt_filter) nfilt++;
      if (nfilt < 2) begin
        s_valid = 1'b1; s_pixel = 8'($urandom);
        step(); cyc++;
      end
    end
    chk("rstmid_reached", nfilt, 2);
    s_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    lc = line_count;
    chk("rstmid_pixel", filt_pixel, 0);
    chk("rstmid_wr", filt_wr, 0);
    chk("rstmid_filter", filt_filter, 0);
    chk("rstmid_enable", filt_enable, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", line_done, 0);
    chk("rstmid_ready", s_ready, 0);
    chk("rstmid_count", lc, 0);
    exp_lines = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (line_done || filt_wr || busy || line_count !== lc) bad++;
    end
    chk("rstmid_quiet", bad, 0);
    $display("reset mid-line quiet_violations=%0d", bad);

    // s_valid held in IDLE is not consumed; the next start takes it as p0
    s_valid = 1'b1; s_pixel = 8'd77; bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_ready || filt_wr) bad++;
    end
    chk("idle_valid_ignored", bad, 0);
    line_px = '{8'd77, 8'($urandom), 8'($urandom)};
    run_line(3, 64'h0, -1);
    idle_check("idle_valid_after");

    // Random lines, random stalls, random back-to-back; passes the count wrap
    for (int n = 0; n < 18; n++) begin
      int wf;
      wf = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      fill_rand((wf == 0) ? 1 : wf);
      mask = '0;
      for (int b = 0; b < 64; b++) mask[b] = ($urandom_range(0, 99) < 30);
      run_line(wf, mask, -1);
      if ($urandom_range(0, 1) == 0) idle_check("rand_after");
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
